mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter sharing the single pmem port between the instruction fetch unit (IFU) and the load/store unit (LSU). Accepts one request at a time over valid/ready handshakes, forwards it to the memory port, waits for the response and routes it back to the owner, with a watchdog that terminates hung transactions. Sits between IFU/LSU and the memory-side port of the multi-cycle core.

## Interface
Parameters:
- `TIMEOUT`, 256, cycles in WAIT before an error response is forced (≥ 2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `ifu_req_valid`  in  1  IFU read request
- `ifu_req_addr`  in  32  IFU address (len fixed 2'b10, word)
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_resp_valid`  out  1  one-cycle response pulse to IFU
- `ifu_resp_data`  out  32  IFU read data
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_addr`  in  32  LSU address
- `lsu_req_wen`  in  1  1 = write, 0 = read
- `lsu_req_wdata`  in  32  write data
- `lsu_req_len`  in  2  size code (00 byte, 01 half, 10 word)
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_resp_valid`  out  1  one-cycle response pulse to LSU
- `lsu_resp_data`  out  32  LSU read data (0 for writes)
- `resp_err`  out  1  qualifies the active resp_valid: timeout
- `mem_req_valid`  out  1  request to memory
- `mem_req_addr` / `mem_req_wdata`  out  32  latched request fields
- `mem_req_wen`  out  1;  `mem_req_len`  out  2
- `mem_req_ready`  in  1  memory accepted request
- `mem_resp_valid`  in  1  memory response strobe
- `mem_resp_data`  in  32  memory read data

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if any req_valid, grant one; assert that requester's `*_req_ready` combinationally the same cycle; latch addr/wen/wdata/len and owner; go REQ. No valid → stay.
- Tie (both valid): LSU wins (see Configuration). Single valid always granted.
- REQ: `mem_req_valid`=1 with latched fields; on `mem_req_ready` go WAIT, clear timeout counter.
- WAIT: counter increments each cycle. On `mem_resp_valid`: register data, pulse owner's `resp_valid` next cycle with `resp_err`=0, go IDLE. If counter reaches TIMEOUT-1 without response: pulse owner's `resp_valid`, `resp_err`=1, data 0, go IDLE.
- `mem_resp_valid` outside WAIT is ignored (late response after timeout dropped).
- `*_req_ready` is never asserted outside IDLE; both never asserted together.
- IFU requests drive `mem_req_wen`=0, `mem_req_len`=2'b10, `wdata`=0.
- Response data passes unmodified; sign/zero extension stays in the LSU.

## Timing
- Reset: state IDLE, all outputs 0, counter 0, owner/latched fields 0, last-grant = LSU.
- Reset mid-transaction: outstanding request dropped, no response pulse generated.
- Min latency: handshake cycle N, `mem_req_valid` N+1, `mem_resp_valid` earliest N+2, `*_resp_valid` N+3.
- Response pulse coincides with return to IDLE; a new grant is possible in that same cycle (back-to-back issue every 3 cycles with zero-latency memory).
- `resp_valid` has no back-pressure; requesters must accept it.
- Counter is `$clog2(TIMEOUT)` bits, saturates never (leaves WAIT at TIMEOUT-1).

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on ties — grant the requester not granted last; last-grant register updates on every grant; reset value LSU, so IFU wins the first tie.
- Undefined: fixed priority, LSU always wins ties; last-grant register not built.

## Structure
- Shared package `mem_arb_pkg`: `arb_state_t` enum (IDLE/REQ/WAIT), `arb_owner_t` enum (OWN_IFU/OWN_LSU), size-code constants (LEN_B/LEN_H/LEN_W).
- One sub-module `mem_arb_pick`: combinational two-way grant selection plus, under `MEM_ARB_RR_EN`, the last-grant register.

## Test plan
- IFU read 0x8000_0000, memory returns 0x0000_0413 one cycle after accept → `ifu_resp_valid` at N+3, data 0x0000_0413, `resp_err`=0, `lsu_resp_valid` stays 0.
- LSU write addr 0x8000_1000 data 0xDEAD_BEEF len 10 → `mem_req_*` carries exactly these, `lsu_resp_valid` pulses once, data 0.
- Both valid in IDLE twice in a row → without macro LSU,LSU; with `MEM_ARB_RR_EN` IFU then LSU.
- `mem_req_ready` held 0 for 5 cycles → `mem_req_valid` and fields stable, no `*_req_ready` asserted.
- No `mem_resp_valid` with TIMEOUT=8 → owner `resp_valid` with `resp_err`=1 after 8 WAIT cycles; late `mem_resp_valid` then ignored.
- `rst` asserted in WAIT → next cycle IDLE, all outputs 0, no response pulse; subsequent IFU request serviced normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;
endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant selection. MEM_ARB_RR_EN selects round-robin tie-breaking
// (with a last-grant register); otherwise the LSU always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);
  logic tie_ifu;

`ifdef MEM_ARB_RR_EN
  arb_owner_t last;

  // Resets to LSU so that the first tie goes to the IFU.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= OWN_LSU;
    end else if (take && (ifu_valid || lsu_valid)) begin
      last <= grant_lsu ? OWN_LSU : OWN_IFU;
    end
  end

  assign tie_ifu = (last == OWN_LSU);
`else
  logic unused_ctl;
  assign unused_ctl = &{1'b0, clk, rst, take};
  assign tie_ifu    = 1'b0;
`endif

  always_comb begin
    grant_ifu = ifu_valid && (!lsu_valid || tie_ifu);
    grant_lsu = lsu_valid && !grant_ifu;
  end
endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter for the single memory port, with a response watchdog.
// Optional round-robin tie-breaking via the MEM_ARB_RR_EN macro.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [1:0]  lsu_req_len,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        resp_err,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic        mem_req_wen,
  output logic [1:0]  mem_req_len,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  arb_state_t       state_nx;
  arb_owner_t       owner;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             grant_ifu;
  logic             grant_lsu;
  logic             done;

  assign take = (state == IDLE);
  assign done = mem_resp_valid || (cnt == CNT_LAST);

  mem_arb_pick u_pick (
    .clk       (clk),
    .rst       (rst),
    .take      (take),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  assign ifu_req_ready = take && grant_ifu;
  assign lsu_req_ready = take && grant_lsu;
  assign mem_req_valid = (state == REQ);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_ifu || grant_lsu) state_nx = REQ;
      REQ:     if (mem_req_ready) state_nx = WAIT;
      WAIT:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Request latch, watchdog and registered response pulse. A response in the
  // same cycle as the last watchdog count still wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner          <= OWN_IFU;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_wen    <= 1'b0;
      mem_req_len    <= '0;
      cnt            <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      resp_err       <= 1'b0;
      ifu_resp_data  <= '0;
      lsu_resp_data  <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      resp_err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner         <= OWN_LSU;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wen   <= lsu_req_wen;
            mem_req_len   <= lsu_req_len;
          end else if (grant_ifu) begin
            owner         <= OWN_IFU;
            mem_req_addr  <= ifu_req_addr;
            mem_req_wdata <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_len   <= LEN_W;
          end
        end
        REQ: begin
          if (mem_req_ready) cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (done) begin
            ifu_resp_valid <= (owner == OWN_IFU);
            lsu_resp_valid <= (owner == OWN_LSU);
            resp_err       <= !mem_resp_valid;
            if (owner == OWN_IFU) begin
              ifu_resp_data <= mem_resp_valid ? mem_resp_data : '0;
            end else begin
              lsu_resp_data <= (mem_resp_valid && !mem_req_wen) ? mem_resp_data : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand sequences for ties,
// stalls, timeout and reset, then randomized transactions against a model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [1:0]  lsu_req_len;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        resp_err;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_wen;
  logic [1:0]  mem_req_len;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int errors = 0;
  int checks = 0;
  bit last_lsu = 1'b1;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_len(lsu_req_len), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wen(mem_req_wen), .mem_req_len(mem_req_len), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "time limit");
  end

  typedef struct {
    bit          ifu_v;
    logic [31:0] ifu_addr;
    bit          lsu_v;
    logic [31:0] lsu_addr;
    bit          wen;
    logic [31:0] wdata;
    logic [1:0]  len;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    bit          exp_lsu;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                         input bit w, input logic [31:0] wd, input logic [1:0] ln);
    ifu_req_valid  = iv;
    ifu_req_addr   = ia;
    lsu_req_valid  = lv;
    lsu_req_addr   = la;
    lsu_req_wen    = w;
    lsu_req_wdata  = wd;
    lsu_req_len    = ln;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      set_req(0, 32'h0, 0, 32'h0, 0, 32'h0, 2'b00);
      #1;
      chk("idle_ifu_ready", ifu_req_ready, 0);
      chk("idle_lsu_ready", lsu_req_ready, 0);
      chk("idle_ifu_resp", ifu_resp_valid, 0);
      chk("idle_lsu_resp", lsu_resp_valid, 0);
      chk("idle_mem_valid", mem_req_valid, 0);
    end
  endtask

  // Called in the cycle a grant is expected; ends in the response-pulse cycle.
  task automatic serve(input bit exp_lsu, input int rdy_dly, input int rsp_dly,
                       input logic [31:0] rdata, input logic [31:0] exp_data, input bit exp_err,
                       input bit after_ifu, input bit after_lsu);
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    logic [1:0]  e_len;
    if (exp_lsu) begin
      e_addr = lsu_req_addr; e_wdata = lsu_req_wdata; e_wen = lsu_req_wen; e_len = lsu_req_len;
    end else begin
      e_addr = ifu_req_addr; e_wdata = 32'h0; e_wen = 1'b0; e_len = LEN_W;
    end
    #1;
    chk("grant_ifu", ifu_req_ready, !exp_lsu);
    chk("grant_lsu", lsu_req_ready, exp_lsu);
    last_lsu = exp_lsu;
    for (int i = 0; i <= rdy_dly; i++) begin
      next_cycle();
      ifu_req_valid  = after_ifu;
      lsu_req_valid  = after_lsu;
      mem_resp_valid = 1'b0;
      mem_req_ready  = (i == rdy_dly);
      #1;
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, e_addr);
      chk("req_wdata", mem_req_wdata, e_wdata);
      chk("req_wen", mem_req_wen, e_wen);
      chk("req_len", mem_req_len, e_len);
      chk("req_ifu_ready", ifu_req_ready, 0);
      chk("req_lsu_ready", lsu_req_ready, 0);
      chk("req_resp", ifu_resp_valid | lsu_resp_valid, 0);
    end
    for (int i = 0; i < TIMEOUT; i++) begin
      next_cycle();
      mem_req_ready  = 1'b0;
      mem_resp_valid = (i == rsp_dly);
      mem_resp_data  = (i == rsp_dly) ? rdata : $urandom;
      #1;
      chk("wait_mem_valid", mem_req_valid, 0);
      chk("wait_ready", ifu_req_ready | lsu_req_ready, 0);
      chk("wait_resp", ifu_resp_valid | lsu_resp_valid, 0);
      if (i == rsp_dly) break;
    end
    next_cycle();
    mem_resp_valid = (rsp_dly >= TIMEOUT);
    mem_resp_data  = 32'hBAD0_0BAD;
    #1;
    chk("resp_ifu_valid", ifu_resp_valid, !exp_lsu);
    chk("resp_lsu_valid", lsu_resp_valid, exp_lsu);
    chk("resp_err", resp_err, exp_err);
    chk("resp_data", exp_lsu ? lsu_resp_data : ifu_resp_data, exp_data);
    chk("resp_mem_valid", mem_req_valid, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifu_ready"}, ifu_req_ready, 0);
    chk({tag, "_lsu_ready"}, lsu_req_ready, 0);
    chk({tag, "_ifu_resp"}, ifu_resp_valid, 0);
    chk({tag, "_lsu_resp"}, lsu_resp_valid, 0);
    chk({tag, "_ifu_data"}, ifu_resp_data, 0);
    chk({tag, "_lsu_data"}, lsu_resp_data, 0);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_wdata"}, mem_req_wdata, 0);
    chk({tag, "_mem_wen"}, mem_req_wen, 0);
    chk({tag, "_mem_len"}, mem_req_len, 0);
  endtask

  initial begin
    bit          pend_ifu, pend_lsu, ex_lsu, ex_err;
    int          rdy, rsp;
    logic [31:0] rd, ed;

    vecs[0] = '{1, 32'h8000_0000, 0, 32'h0,         0, 32'h0,         LEN_W, 0, 0,  32'h0000_0413, 0, 0, 32'h0000_0413};
    vecs[1] = '{0, 32'h0,         1, 32'h8000_1000, 1, 32'hDEAD_BEEF, LEN_W, 0, 0,  32'h1234_5678, 1, 0, 32'h0};
    vecs[2] = '{0, 32'h0,         1, 32'h8000_1003, 0, 32'h5555_5555, LEN_B, 5, 3,  32'hFFFF_FF80, 1, 0, 32'hFFFF_FF80};
    vecs[3] = '{1, 32'h8000_0004, 0, 32'h0,         0, 32'h0,         LEN_W, 0, 20, 32'hCAFE_0001, 0, 1, 32'h0};
    vecs[4] = '{0, 32'h0,         1, 32'h8000_2002, 0, 32'h0,         LEN_H, 1, 7,  32'h0000_8001, 1, 0, 32'h0000_8001};
    vecs[5] = '{0, 32'h0,         1, 32'h8000_3000, 1, 32'h0BAD_F00D, LEN_W, 2, 9,  32'h7777_7777, 1, 1, 32'h0};
    vecs[6] = '{1, 32'h8000_0ABC, 0, 32'h0,         0, 32'h0,         LEN_W, 2, 6,  32'hA5A5_5A5A, 0, 0, 32'hA5A5_5A5A};

    rst = 1'b1;
    mem_resp_data = 32'h0;
    set_req(0, 32'h0, 0, 32'h0, 0, 32'h0, 2'b00);
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // Two ties in a row, then the leftover IFU request.
    next_cycle();
    set_req(1, 32'h8000_0100, 1, 32'h8000_2000, 0, 32'h0, LEN_W);
`ifdef MEM_ARB_RR_EN
    serve(0, 0, 0, 32'h1111_1111, 32'h1111_1111, 0, 1, 1);
`else
    serve(1, 0, 0, 32'h1111_1111, 32'h1111_1111, 0, 1, 1);
`endif
    serve(1, 0, 0, 32'h2222_2222, 32'h2222_2222, 0, 1, 0);
    serve(0, 0, 0, 32'h3333_3333, 32'h3333_3333, 0, 0, 0);
    idle(2);

    foreach (vecs[i]) begin
      next_cycle();
      set_req(vecs[i].ifu_v, vecs[i].ifu_addr, vecs[i].lsu_v, vecs[i].lsu_addr,
              vecs[i].wen, vecs[i].wdata, vecs[i].len);
      serve(vecs[i].exp_lsu, vecs[i].rdy_dly, vecs[i].rsp_dly, vecs[i].rdata,
            vecs[i].exp_data, vecs[i].exp_err, 0, 0);
      idle(1);
    end

    // Reset while waiting for memory: no pulse, late data ignored.
    next_cycle();
    set_req(1, 32'h8000_0040, 0, 32'h0, 0, 32'h0, LEN_W);
    #1;
    chk("rstw_grant", ifu_req_ready, 1);
    next_cycle();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h4444_4444;
    #1;
    chk_all_zero("rstw");
    last_lsu = 1'b1;
    idle(3);
    next_cycle();
    set_req(1, 32'h8000_0080, 0, 32'h0, 0, 32'h0, LEN_W);
    serve(0, 0, 1, 32'h0000_0513, 32'h0000_0513, 0, 0, 0);

    // Randomized traffic against the transaction-level model.
    pend_ifu = 1'b0;
    pend_lsu = 1'b0;
    for (int t = 0; t < 150; t++) begin
      if (!pend_ifu && !pend_lsu && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (!pend_ifu && $urandom_range(0, 1) == 1) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!pend_lsu && ($urandom_range(0, 1) == 1 || !ifu_req_valid)) begin
        lsu_req_valid = 1'b1;
        lsu_req_addr  = $urandom;
        lsu_req_wen   = $urandom_range(0, 1);
        lsu_req_wdata = $urandom;
        lsu_req_len   = 2'($urandom_range(0, 2));
      end
      if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
        ex_lsu = !last_lsu;
`else
        ex_lsu = 1'b1;
`endif
      end else begin
        ex_lsu = lsu_req_valid;
      end
      pend_ifu = ifu_req_valid && ex_lsu;
      pend_lsu = lsu_req_valid && !ex_lsu;
      rdy    = $urandom_range(0, 3);
      rsp    = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2) : $urandom_range(0, TIMEOUT - 1);
      rd     = $urandom;
      ex_err = (rsp >= TIMEOUT);
      ed     = (ex_err || (ex_lsu && lsu_req_wen)) ? 32'h0 : rd;
      serve(ex_lsu, rdy, rsp, rd, ed, ex_err, pend_ifu, pend_lsu);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
